rvfi_insn_check_seq: RTL

- Sequential, parametrised successor to the per-channel combinational instruction checker.
- Captures RVFI retirements from all NRET channels into an order-preserving queue.
- Checks each retirement, one per cycle, against a single shared `rvfi_insn_<INSN>` spec instance.
- Additionally checks that the rvfi_order sequence has no gaps and reports queue overflow; the first failure is latched with its order number.
- Sits in the formal/sim harness beside the other rvfi checks and drives a single assert on check_fail.

---
 rtl/rvfi_check_pkg.sv | 62 ++++++
 rtl/rvfi_insn_addi.sv | 46 ++++
 rtl/rvfi_insn_compare.sv | 55 +++++
 rtl/rvfi_insn_check_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_check_pkg.sv
// rtl/rvfi_check_pkg.sv - shared error codes and queue entry records for rvfi checkers
`ifndef RVFI_CHECK_MAX_XLEN
`define RVFI_CHECK_MAX_XLEN 64
`endif
`ifndef RVFI_CHECK_MAX_ORDER_W
`define RVFI_CHECK_MAX_ORDER_W 64
`endif

package rvfi_check_pkg;

  // Records are sized for the widest supported core; narrower cores zero-extend.
  localparam int MAX_XLEN    = `RVFI_CHECK_MAX_XLEN;
  localparam int MAX_ORDER_W = `RVFI_CHECK_MAX_ORDER_W;
  localparam int MAX_MASK_W  = MAX_XLEN / 8;

  localparam logic [3:0] ERR_NONE      = 4'd0;
  localparam logic [3:0] ERR_RS1       = 4'd1;
  localparam logic [3:0] ERR_RS2       = 4'd2;
  localparam logic [3:0] ERR_RD_ADDR   = 4'd3;
  localparam logic [3:0] ERR_RD_WDATA  = 4'd4;
  localparam logic [3:0] ERR_PC_WDATA  = 4'd5;
  localparam logic [3:0] ERR_MEM_ADDR  = 4'd6;
  localparam logic [3:0] ERR_MEM_WRITE = 4'd7;
  localparam logic [3:0] ERR_MEM_READ  = 4'd8;
  localparam logic [3:0] ERR_TRAP      = 4'd9;
  localparam logic [3:0] ERR_ORDER     = 4'd10;
  localparam logic [3:0] ERR_OVERFLOW  = 4'd11;

  typedef struct packed {
    logic [31:0]             insn;
    logic [MAX_ORDER_W-1:0]  order;
    logic                    trap;
    logic [4:0]              rs1_addr;
    logic [4:0]              rs2_addr;
    logic [4:0]              rd_addr;
    logic [MAX_XLEN-1:0]     pc_rdata;
    logic [MAX_XLEN-1:0]     pc_wdata;
    logic [MAX_XLEN-1:0]     rs1_rdata;
    logic [MAX_XLEN-1:0]     rs2_rdata;
    logic [MAX_XLEN-1:0]     rd_wdata;
    logic [MAX_XLEN-1:0]     mem_addr;
    logic [MAX_XLEN-1:0]     mem_rdata;
    logic [MAX_XLEN-1:0]     mem_wdata;
    logic [MAX_MASK_W-1:0]   mem_rmask;
    logic [MAX_MASK_W-1:0]   mem_wmask;
  } entry_t;

  typedef struct packed {
    logic                    valid;
    logic                    trap;
    logic [4:0]              rs1_addr;
    logic [4:0]              rs2_addr;
    logic [4:0]              rd_addr;
    logic [MAX_XLEN-1:0]     rd_wdata;
    logic [MAX_XLEN-1:0]     pc_wdata;
    logic [MAX_XLEN-1:0]     mem_addr;
    logic [MAX_XLEN-1:0]     mem_wdata;
    logic [MAX_MASK_W-1:0]   mem_rmask;
    logic [MAX_MASK_W-1:0]   mem_wmask;
  } spec_t;

endpackage

// File: rtl/rvfi_insn_addi.sv
// rtl/rvfi_insn_addi.sv - ADDI instruction spec model for the rvfi insn checkers
module rvfi_insn_addi #(
  parameter int XLEN = 32
) (
  input  logic                rvfi_valid,
  input  logic [31:0]         rvfi_insn,
  input  logic [XLEN-1:0]     rvfi_pc_rdata,
  input  logic [XLEN-1:0]     rvfi_rs1_rdata,
  input  logic [XLEN-1:0]     rvfi_rs2_rdata,
  input  logic [XLEN-1:0]     rvfi_mem_rdata,
  output logic                spec_valid,
  output logic                spec_trap,
  output logic [4:0]          spec_rs1_addr,
  output logic [4:0]          spec_rs2_addr,
  output logic [4:0]          spec_rd_addr,
  output logic [XLEN-1:0]     spec_rd_wdata,
  output logic [XLEN-1:0]     spec_pc_wdata,
  output logic [XLEN-1:0]     spec_mem_addr,
  output logic [XLEN/8-1:0]   spec_mem_rmask,
  output logic [XLEN/8-1:0]   spec_mem_wmask,
  output logic [XLEN-1:0]     spec_mem_wdata
);

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] result;
  logic            unused_inputs;

  assign imm    = {{(XLEN-12){rvfi_insn[31]}}, rvfi_insn[31:20]};
  assign result = rvfi_rs1_rdata + imm;

  assign spec_valid     = rvfi_valid && rvfi_insn[6:0] == 7'b0010011 && rvfi_insn[14:12] == 3'b000;
  assign spec_rs1_addr  = rvfi_insn[19:15];
  assign spec_rs2_addr  = 5'd0;
  assign spec_rd_addr   = rvfi_insn[11:7];
  assign spec_rd_wdata  = (|spec_rd_addr) ? result : '0;
  assign spec_pc_wdata  = rvfi_pc_rdata + XLEN'(4);
  // Without compressed support the next pc must be word aligned.
  assign spec_trap      = |spec_pc_wdata[1:0];
  assign spec_mem_addr  = '0;
  assign spec_mem_rmask = '0;
  assign spec_mem_wmask = '0;
  assign spec_mem_wdata = '0;

  assign unused_inputs = ^{rvfi_rs2_rdata, rvfi_mem_rdata};

endmodule

// File: rtl/rvfi_insn_compare.sv
// rtl/rvfi_insn_compare.sv - compares one retired entry against spec outputs, returns error code
module rvfi_insn_compare
  import rvfi_check_pkg::*;
(
  input  entry_t      entry,
  input  spec_t       spec,
  output logic [3:0]  err_code
);

  logic mem_w_bad;
  logic mem_r_bad;
  logic unused_fields;

  always_comb begin
    mem_w_bad = 1'b0;
    for (int i = 0; i < MAX_MASK_W; i++) begin
      if (spec.mem_wmask[i]) begin
        if (!entry.mem_wmask[i] || entry.mem_wdata[8*i +: 8] != spec.mem_wdata[8*i +: 8])
          mem_w_bad = 1'b1;
      end else if (entry.mem_wmask[i]) begin
        // Extra written bytes are tolerated only as read-modify-write of unchanged data.
        if (!entry.mem_rmask[i] || entry.mem_rdata[8*i +: 8] != entry.mem_wdata[8*i +: 8])
          mem_w_bad = 1'b1;
      end
    end
    mem_r_bad = |(spec.mem_rmask & ~entry.mem_rmask);
  end

  always_comb begin
    err_code = ERR_NONE;
    if (spec.valid) begin
      if (|spec.rs1_addr && entry.rs1_addr != spec.rs1_addr)
        err_code = ERR_RS1;
      else if (|spec.rs2_addr && entry.rs2_addr != spec.rs2_addr)
        err_code = ERR_RS2;
      else if (!spec.trap && entry.rd_addr != spec.rd_addr)
        err_code = ERR_RD_ADDR;
      else if (!spec.trap && entry.rd_wdata != spec.rd_wdata)
        err_code = ERR_RD_WDATA;
      else if (!spec.trap && entry.pc_wdata != spec.pc_wdata)
        err_code = ERR_PC_WDATA;
      else if (!spec.trap && |(spec.mem_rmask | spec.mem_wmask) && entry.mem_addr != spec.mem_addr)
        err_code = ERR_MEM_ADDR;
      else if (!spec.trap && mem_w_bad)
        err_code = ERR_MEM_WRITE;
      else if (!spec.trap && mem_r_bad)
        err_code = ERR_MEM_READ;
      else if (entry.trap != spec.trap)
        err_code = ERR_TRAP;
    end
  end

  assign unused_fields = ^{entry.insn, entry.order, entry.pc_rdata, entry.rs1_rdata, entry.rs2_rdata};

endmodule

// File: rtl/rvfi_insn_check_seq.sv
// rtl/rvfi_insn_check_seq.sv - queued, one-per-cycle rvfi instruction checker with order tracking
module rvfi_insn_check_seq
  import rvfi_check_pkg::*;
#(
  parameter int NRET    = 1,
  parameter int XLEN    = 32,
  parameter int ORDER_W = 64,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [NRET-1:0]        rvfi_valid,
  input  logic [NRET*ORDER_W-1:0] rvfi_order,
  input  logic [NRET*32-1:0]     rvfi_insn,
  input  logic [NRET-1:0]        rvfi_trap,
  input  logic [NRET*5-1:0]      rvfi_rs1_addr,
  input  logic [NRET*5-1:0]      rvfi_rs2_addr,
  input  logic [NRET*5-1:0]      rvfi_rd_addr,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_wdata,
  input  logic [NRET*XLEN-1:0]   rvfi_rs1_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_rs2_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_rd_wdata,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_addr,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_wdata,
  input  logic [NRET*XLEN/8-1:0] rvfi_mem_rmask,
  input  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask,
  output logic                   check_valid,
  output logic                   check_fail,
  output logic [3:0]             err_code,
  output logic [ORDER_W-1:0]     err_order,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = XLEN / 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAIL} state_t;

  entry_t             mem [DEPTH];
  entry_t             in_entry [NRET];
  logic [PW-1:0]      slot_ofs [NRET];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW-1:0]      n_valid, used, free_slots;
  logic [ORDER_W-1:0] drop_order;
  logic               push, overflow, pop;

  entry_t             head;
  logic [ORDER_W-1:0] head_order;
  spec_t              spec;
  logic [3:0]         cmp_code;

  state_t             state, state_d;
  logic [ORDER_W-1:0] exp_order, exp_d;
  logic               valid_d, fail_d;
  logic [3:0]         code_d, entry_code;
  logic [ORDER_W-1:0] order_d;

  always_comb begin
    for (int ch = 0; ch < NRET; ch++) begin
      in_entry[ch]           = '0;
      in_entry[ch].insn      = rvfi_insn[ch*32 +: 32];
      in_entry[ch].order     = MAX_ORDER_W'(rvfi_order[ch*ORDER_W +: ORDER_W]);
      in_entry[ch].trap      = rvfi_trap[ch];
      in_entry[ch].rs1_addr  = rvfi_rs1_addr[ch*5 +: 5];
      in_entry[ch].rs2_addr  = rvfi_rs2_addr[ch*5 +: 5];
      in_entry[ch].rd_addr   = rvfi_rd_addr[ch*5 +: 5];
      in_entry[ch].pc_rdata  = MAX_XLEN'(rvfi_pc_rdata[ch*XLEN +: XLEN]);
      in_entry[ch].pc_wdata  = MAX_XLEN'(rvfi_pc_wdata[ch*XLEN +: XLEN]);
      in_entry[ch].rs1_rdata = MAX_XLEN'(rvfi_rs1_rdata[ch*XLEN +: XLEN]);
      in_entry[ch].rs2_rdata = MAX_XLEN'(rvfi_rs2_rdata[ch*XLEN +: XLEN]);
      in_entry[ch].rd_wdata  = MAX_XLEN'(rvfi_rd_wdata[ch*XLEN +: XLEN]);
      in_entry[ch].mem_addr  = MAX_XLEN'(rvfi_mem_addr[ch*XLEN +: XLEN]);
      in_entry[ch].mem_rdata = MAX_XLEN'(rvfi_mem_rdata[ch*XLEN +: XLEN]);
      in_entry[ch].mem_wdata = MAX_XLEN'(rvfi_mem_wdata[ch*XLEN +: XLEN]);
      in_entry[ch].mem_rmask = MAX_MASK_W'(rvfi_mem_rmask[ch*MW +: MW]);
      in_entry[ch].mem_wmask = MAX_MASK_W'(rvfi_mem_wmask[ch*MW +: MW]);
    end
  end

  // Valid channels are packed into consecutive slots in ascending channel order.
  always_comb begin
    n_valid    = '0;
    drop_order = '0;
    for (int ch = 0; ch < NRET; ch++) begin
      slot_ofs[ch] = n_valid;
      n_valid      = n_valid + PW'(rvfi_valid[ch]);
    end
    for (int ch = NRET - 1; ch >= 0; ch--)
      if (rvfi_valid[ch]) drop_order = rvfi_order[ch*ORDER_W +: ORDER_W];
  end

  assign used       = wr_ptr - rd_ptr;
  assign free_slots = PW'(DEPTH) - used;
  assign push       = enable && (|n_valid) && n_valid <= free_slots;
  assign overflow   = enable && n_valid > free_slots;
  assign pop        = wr_ptr != rd_ptr;
  assign busy       = pop;

  always_ff @(posedge clk) begin
    if (push)
      for (int ch = 0; ch < NRET; ch++)
        if (rvfi_valid[ch]) mem[AW'(wr_ptr + slot_ofs[ch])] <= in_entry[ch];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + n_valid;
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_order = head.order[ORDER_W-1:0];

  logic              spec_valid, spec_trap;
  logic [4:0]        spec_rs1_addr, spec_rs2_addr, spec_rd_addr;
  logic [XLEN-1:0]   spec_rd_wdata, spec_pc_wdata, spec_mem_addr, spec_mem_wdata;
  logic [MW-1:0]     spec_mem_rmask, spec_mem_wmask;

  rvfi_insn_addi #(.XLEN(XLEN)) u_spec (
    .rvfi_valid     (pop),
    .rvfi_insn      (head.insn),
    .rvfi_pc_rdata  (head.pc_rdata[XLEN-1:0]),
    .rvfi_rs1_rdata (head.rs1_rdata[XLEN-1:0]),
    .rvfi_rs2_rdata (head.rs2_rdata[XLEN-1:0]),
    .rvfi_mem_rdata (head.mem_rdata[XLEN-1:0]),
    .spec_valid     (spec_valid),
    .spec_trap      (spec_trap),
    .spec_rs1_addr  (spec_rs1_addr),
    .spec_rs2_addr  (spec_rs2_addr),
    .spec_rd_addr   (spec_rd_addr),
    .spec_rd_wdata  (spec_rd_wdata),
    .spec_pc_wdata  (spec_pc_wdata),
    .spec_mem_addr  (spec_mem_addr),
    .spec_mem_rmask (spec_mem_rmask),
    .spec_mem_wmask (spec_mem_wmask),
    .spec_mem_wdata (spec_mem_wdata)
  );

  always_comb begin
    spec           = '0;
    spec.valid     = spec_valid;
    spec.trap      = spec_trap;
    spec.rs1_addr  = spec_rs1_addr;
    spec.rs2_addr  = spec_rs2_addr;
    spec.rd_addr   = spec_rd_addr;
    spec.rd_wdata  = MAX_XLEN'(spec_rd_wdata);
    spec.pc_wdata  = MAX_XLEN'(spec_pc_wdata);
    spec.mem_addr  = MAX_XLEN'(spec_mem_addr);
    spec.mem_wdata = MAX_XLEN'(spec_mem_wdata);
    spec.mem_rmask = MAX_MASK_W'(spec_mem_rmask);
    spec.mem_wmask = MAX_MASK_W'(spec_mem_wmask);
  end

  rvfi_insn_compare u_compare (
    .entry    (head),
    .spec     (spec),
    .err_code (cmp_code)
  );

  always_comb begin
    state_d    = state;
    exp_d      = exp_order;
    valid_d    = 1'b0;
    fail_d     = check_fail;
    code_d     = err_code;
    order_d    = err_order;
    entry_code = cmp_code;
    if (state == S_RUN && cmp_code == ERR_NONE && head_order != exp_order)
      entry_code = ERR_ORDER;
    if (state != S_FAIL) begin
      if (pop) begin
        valid_d = 1'b1;
        state_d = S_RUN;
        exp_d   = ((state == S_IDLE) ? head_order : exp_order) + ORDER_W'(1);
        if (entry_code != ERR_NONE) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
          code_d  = entry_code;
          order_d = head_order;
        end
      end
      // A dropped group outranks whatever the popped entry reported this cycle.
      if (overflow) begin
        state_d = S_FAIL;
        fail_d  = 1'b1;
        code_d  = ERR_OVERFLOW;
        order_d = drop_order;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      exp_order   <= '0;
      check_valid <= 1'b0;
      check_fail  <= 1'b0;
      err_code    <= ERR_NONE;
      err_order   <= '0;
    end else begin
      state       <= state_d;
      exp_order   <= exp_d;
      check_valid <= valid_d;
      check_fail  <= fail_d;
      err_code    <= code_d;
      err_order   <= order_d;
    end
  end

endmodule
